// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and the memory slave FSM states
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2;
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
endpackage

// File: rtl/ahb_mem_slave_if.sv
// ahb_mem_slave_if: muxed AHB request bus and slave response signals
interface ahb_mem_slave_if #(parameter int ADDR_W = 32);
  logic hsel, hwrite, hready, hreadyout, hresp;
  logic [ADDR_W-1:0] haddr;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [31:0] hwdata, hrdata;
  modport master (output hsel, haddr, hwrite, htrans, hsize, hwdata, hready, input hreadyout, hresp, hrdata);
  modport slave (input hsel, haddr, hwrite, htrans, hsize, hwdata, hready, output hreadyout, hresp, hrdata);
endinterface

// File: rtl/ahb_byte_strobe.sv
// ahb_byte_strobe: little-endian byte lane strobes and alignment check for an AHB access
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [2:0] hsize,
  output logic [3:0] strobe,
  output logic       misalign
);
  always_comb begin
    strobe = hsize == HSIZE_BYTE ? 4'b0001 << addr :
             hsize == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
             hsize == HSIZE_WORD ? 4'b1111 : 4'b0000;
    misalign = hsize > HSIZE_WORD || (hsize == HSIZE_HALF && addr[0]) || (hsize == HSIZE_WORD && addr != 2'b00);
  end
endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: word-organised AHB memory with wait states and two-cycle ERROR response
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input logic hclk,
  input logic hreset,
  ahb_mem_slave_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, strb, strb_q;
  logic [IW-1:0] idx_q;
  logic write_q, mis, err, cap, done, ready, resp;
  logic [31:0] mem [DEPTH];
  ahb_byte_strobe u_strobe (.addr(bus.haddr[1:0]), .hsize(bus.hsize), .strobe(strb), .misalign(mis));
  assign err = mis || (bus.haddr >> 2) >= ADDR_W'(DEPTH);
  // every good transfer passes through WAIT; a zero count there is the completing cycle
  assign done = state == WAIT && cnt == 4'd0;
  assign bus.hreadyout = ready;
  assign bus.hresp = resp;
  assign bus.hrdata = done && !write_q ? mem[idx_q] : 32'h0;
  always_comb begin
    ready = state != ERR1 && (state != WAIT || cnt == 4'd0);
    resp = state == ERR1 || state == ERR2 ? HRESP_ERROR : HRESP_OKAY;
    cap = bus.hsel && bus.hready && ready && bus.htrans[1];
    state_n = state == ERR1 ? ERR2 : state == ERR2 || done ? IDLE : state;
    cnt_n = state == WAIT && !done ? cnt - 4'd1 : cnt;
    if (cap) begin
      state_n = err ? ERR1 : WAIT;
      cnt_n = 4'(WAIT_STATES);
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      idx_q <= '0;
      write_q <= 1'b0;
      strb_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (cap) begin
        idx_q <= bus.haddr[IW+1:2];
        write_q <= bus.hwrite;
        strb_q <= strb;
      end
      if (done && write_q)
        for (int b = 0; b < 4; b++)
          if (strb_q[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: scoreboard bench driving a zero-wait and a three-wait memory slave
module tb_ahb_mem_slave;
  import ahb_pkg::*;
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    bit          err;
  } stim_t;
  typedef struct {
    bit          w;
    bit          err;
    logic [31:0] wd;
    logic [31:0] rd;
    int          cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic sel = 1'b0, decoy_en = 1'b0;
  logic hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = HTRANS_IDLE;
  logic [2:0] hsize = HSIZE_WORD;
  logic ro, rp;
  logic [31:0] rd;
  logic [31:0] model [2][256];
  stim_t stim[$];
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ahb_mem_slave_if #(.ADDR_W(32)) b0 ();
  ahb_mem_slave_if #(.ADDR_W(32)) b3 ();
  ahb_mem_slave #(.DEPTH(256), .WAIT_STATES(0), .ADDR_W(32)) dut0 (.hclk(clk), .hreset(rst), .bus(b0));
  ahb_mem_slave #(.DEPTH(256), .WAIT_STATES(3), .ADDR_W(32)) dut3 (.hclk(clk), .hreset(rst), .bus(b3));
  assign b0.hsel = hsel & ~sel;
  assign b3.hsel = hsel & sel;
  assign b0.haddr = haddr;
  assign b3.haddr = haddr;
  assign b0.hwrite = hwrite;
  assign b3.hwrite = hwrite;
  assign b0.htrans = htrans;
  assign b3.htrans = htrans;
  assign b0.hsize = hsize;
  assign b3.hsize = hsize;
  assign b0.hwdata = hwdata;
  assign b3.hwdata = hwdata;
  assign b0.hready = b0.hreadyout;
  assign b3.hready = b3.hreadyout;
  assign ro = sel ? b3.hreadyout : b0.hreadyout;
  assign rp = sel ? b3.hresp : b0.hresp;
  assign rd = sel ? b3.hrdata : b0.hrdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic add(input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd, input bit err);
    stim_t s;
    s.w = w; s.a = a; s.sz = sz; s.wd = wd; s.err = err;
    stim.push_back(s);
  endtask
  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) model[d][i] = '0;
  endtask
  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int i;
    i = int'(a[9:2]);
    for (int l = 0; l < 4; l++)
      if (sz == 3'd2 || (sz == 3'd0 && l == int'(a[1:0])) || (sz == 3'd1 && l / 2 == int'(a[1])))
        model[d][i][8*l +: 8] = wd[8*l +: 8];
  endtask
  task automatic bus_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0; hsize = HSIZE_WORD;
  endtask
  // Presents queued address phases, holding each until the slave is ready, and
  // checks every data phase against the scoreboard entry pushed at capture.
  task automatic run(input int ws);
    stim_t s;
    exp_t e;
    bit pres;
    int d, guard;
    d = sel ? 1 : 0;
    guard = 0;
    while ((stim.size() > 0 || sb.size() > 0) && guard < 200) begin
      guard++;
      @(posedge clk); #1;
      hwdata = sb.size() > 0 ? sb[0].wd : 32'h0;
      pres = 1'b0;
      if (decoy_en && !ro) begin
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h800; hsize = HSIZE_WORD;
      end else if (stim.size() > 0) begin
        s = stim[0];
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = s.w; haddr = s.a; hsize = s.sz; pres = 1'b1;
      end else bus_idle();
      @(negedge clk);
      if (sb.size() > 0) begin
        sb[0].cyc++;
        e = sb[0];
        if (e.err) begin
          if (e.cyc == 1) begin
            check("err1_ready", 32'(ro), 32'd0);
            check("err1_resp", 32'(rp), 32'd1);
            check("err1_rdata", rd, 32'h0);
          end else begin
            check("err2_ready", 32'(ro), 32'd1);
            check("err2_resp", 32'(rp), 32'd1);
            check("err2_rdata", rd, 32'h0);
            void'(sb.pop_front());
          end
        end else if (ro) begin
          check("latency", 32'(e.cyc), 32'(ws + 1));
          check("ok_resp", 32'(rp), 32'd0);
          if (!e.w) check("rdata", rd, e.rd);
          void'(sb.pop_front());
        end else begin
          check("wait_resp", 32'(rp), 32'd0);
          check("wait_rdata", rd, 32'h0);
          if (e.cyc > ws) begin
            check("wait_overrun", 32'(e.cyc), 32'(ws));
            void'(sb.pop_front());
          end
        end
      end
      if (pres && ro) begin
        void'(stim.pop_front());
        e.w = s.w; e.err = s.err; e.wd = s.w ? s.wd : 32'h0; e.cyc = 0;
        e.rd = model[d][int'(s.a[9:2])];
        sb.push_back(e);
        if (s.w && !s.err) model_write(d, s.a, s.sz, s.wd);
      end
    end
    check("run_drained", 32'(stim.size() + sb.size()), 32'd0);
    stim.delete();
    sb.delete();
    @(posedge clk); #1;
    bus_idle();
    hwdata = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready0", 32'(b0.hreadyout), 32'd1);
    check("rst_resp0", 32'(b0.hresp), 32'd0);
    check("rst_rdata0", b0.hrdata, 32'h0);
    check("rst_ready3", 32'(b3.hreadyout), 32'd1);
    check("rst_resp3", 32'(b3.hresp), 32'd0);
    check("rst_rdata3", b3.hrdata, 32'h0);
    sel = 1'b0;
    add(1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 0);
    add(0, 32'h10, HSIZE_WORD, 32'h0, 0);
    add(1, 32'h13, HSIZE_BYTE, 32'hAA000000, 0);
    add(0, 32'h10, HSIZE_WORD, 32'h0, 0);
    add(1, 32'h11, HSIZE_HALF, 32'h00001234, 1);
    add(0, 32'h10, HSIZE_WORD, 32'h0, 0);
    add(0, 32'h400, HSIZE_WORD, 32'h0, 1);
    add(1, 32'h16, HSIZE_HALF, 32'hBEEF0000, 0);
    add(1, 32'h14, HSIZE_BYTE, 32'h00000011, 0);
    add(0, 32'h14, HSIZE_WORD, 32'h0, 0);
    add(1, 32'h18, 3'd3, 32'hFFFFFFFF, 1);
    add(1, 32'h1A, HSIZE_WORD, 32'hFFFFFFFF, 1);
    add(0, 32'h18, HSIZE_WORD, 32'h0, 0);
    add(1, 32'h3FC, HSIZE_WORD, 32'h0BADF00D, 0);
    add(0, 32'h3FC, HSIZE_WORD, 32'h0, 0);
    run(0);
    sel = 1'b1;
    decoy_en = 1'b1;
    add(1, 32'h0, HSIZE_WORD, 32'h00005555, 0);
    add(0, 32'h0, HSIZE_WORD, 32'h0, 0);
    add(0, 32'h404, HSIZE_WORD, 32'h0, 1);
    add(0, 32'h0, HSIZE_WORD, 32'h0, 0);
    run(3);
    // Reset lands while the write is still counting wait states.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h20; hsize = HSIZE_WORD;
    @(negedge clk);
    check("rst_cap_ready", 32'(ro), 32'd1);
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h12345678;
    @(negedge clk);
    check("rst_wait_ready", 32'(ro), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hwdata = '0;
    model_clear();
    @(negedge clk);
    check("rst_mid_ready", 32'(ro), 32'd1);
    check("rst_mid_resp", 32'(rp), 32'd0);
    check("rst_mid_rdata", rd, 32'h0);
    add(0, 32'h20, HSIZE_WORD, 32'h0, 0);
    add(0, 32'h0, HSIZE_WORD, 32'h0, 0);
    run(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- AHB responder at the far end of the master-to-slave write/address mux; it is the slave-side target of the muxed haddr/hwdata/hready bus.
- Word-organised on-chip memory with configurable wait states, byte/halfword/word access and two-cycle ERROR response.
- Drives hrdata/hreadyout/hresp back toward the masters through the bus read/response path.

Parameters:
- DEPTH, 256, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- WAIT_STATES, 0, cycles hreadyout is held low before a good data phase completes (0..15).
- ADDR_W, 32, haddr width.

Ports:
- hclk  input  1  bus clock; all state on rising edge.
- hreset  input  1  synchronous, active-high reset.
- hsel  input  1  slave select from address decoder.
- haddr  input  32  muxed transfer address (address phase).
- hwrite  input  1  1=write, 0=read (address phase).
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  input  3  0=byte, 1=halfword, 2=word; others illegal.
- hwdata  input  32  muxed write data (data phase).
- hready  input  1  bus-level ready; an address phase is accepted only when high.
- hreadyout  output  1  this slave's ready.
- hresp  output  1  0=OKAY, 1=ERROR.
- hrdata  output  32  read data.

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, memory cleared to 0, captured phase registers cleared.
- Reset mid-transfer aborts the transfer. No memory write occurs for it.
- Address-phase capture happens when hsel & hready & htrans[1]. It registers addr_q, write_q, size_q and err_q.
- IDLE/BUSY transfers, or an unselected slave: no capture; hreadyout=1, hresp=0.
- err_q=1 under any of these conditions:
  - word index haddr[ADDR_W-1:2] >= DEPTH;
  - hsize>2;
  - hsize=1 with haddr[0]=1;
  - hsize=2 with haddr[1:0]!=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE, on capture:
  - err_q=1 -> ERR1;
  - else if WAIT_STATES>0 -> WAIT, with the counter loaded to WAIT_STATES;
  - else the data phase is the next cycle, which completes immediately (hreadyout=1, state stays IDLE/active).
- WAIT: hreadyout=0, hresp=0, counter decrements each cycle. When it reaches 0 the completing cycle has hreadyout=1.
- ERR1: hreadyout=0, hresp=1; then ERR2.
- ERR2: hreadyout=1, hresp=1; then IDLE, or a new data phase if a capture occurs in ERR2.
- Good transfer latency: the data phase lasts WAIT_STATES+1 cycles. Error transfers always last 2 cycles. Memory is never modified on error.
- Write commit: on the clock edge ending the completing cycle, mem[addr_q word] is updated using byte strobes (little-endian):
  - byte: lane addr_q[1:0];
  - halfword: lanes {addr_q[1],0} and {addr_q[1],1};
  - word: all 4 lanes.
  - Write data is sampled from hwdata in that cycle.
- Read: in the completing cycle, hrdata = full word mem[addr_q word] (combinational read, no lane masking). hrdata=0 at all other times, including error phases.
- Pipelining: a new address phase is captured in the completing/ERR2 cycle (hready=1), giving back-to-back transfers with no idle cycle.
- Write followed immediately by a read of the same word returns the newly written data.
- Capture is not permitted while hreadyout=0: any address phase presented while hready=0 is ignored.

Decomposition:
- ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR;
  - HSIZE_BYTE/HALF/WORD;
  - the FSM state enum (IDLE, WAIT, ERR1, ERR2).
- One sub-module, ahb_byte_strobe: combinational; inputs addr[1:0] and hsize; outputs 4-bit strobe and misalign flag. It is shared with future slaves.

Test Plan:
- Reset, then word write 0xDEADBEEF at 0x10 and word read at 0x10, WAIT_STATES=0 -> both complete in 1 data cycle; hrdata=0xDEADBEEF; hresp=0.
- Byte write 0xAA at 0x13, then word read 0x10 -> hrdata=0xAAADBEEF.
- Halfword write 0x1234 at 0x11 -> 2-cycle ERROR: hreadyout 0 then 1, hresp=1 both cycles; a subsequent read of 0x10 is unchanged.
- Read at 4*DEPTH (0x400 for DEPTH=256) -> ERROR sequence; hrdata=0.
- WAIT_STATES=3, word write 0x0000_5555 at 0x0 followed back-to-back by a read of 0x0 -> hreadyout low 3 cycles per transfer; read returns 0x00005555; a NONSEQ presented while hready=0 is not captured.
- Reset asserted during the WAIT of a write -> outputs return to reset values next cycle; memory word unchanged (0).
